// File: rtl/rice_pkg.sv
// Shared types and sizes for the Golomb-Rice encoder and its bit packer.
package rice_pkg;

  localparam int unsigned W_DATA = 16;
  localparam int unsigned W_K    = 4;
  localparam int unsigned Q_ESC  = 16;
  localparam int unsigned W_OUT  = 32;
  localparam int unsigned W_ACC  = 2 * W_OUT;
  localparam int unsigned W_FILL = $clog2(W_ACC);
  localparam int unsigned W_SH   = W_FILL + 1;
  localparam int unsigned W_LEN  = $clog2(W_OUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // Bit length of the prefix (zero run plus terminating one) or of the suffix.
  function automatic logic [W_LEN-1:0] seg_len(input logic             is_prefix,
                                               input logic             esc,
                                               input logic [W_DATA-1:0] q,
                                               input logic [W_K-1:0]    k);
    if (is_prefix) begin
      return esc ? W_LEN'(Q_ESC + 1) : W_LEN'(q) + W_LEN'(1);
    end
    return esc ? W_LEN'(W_DATA) : W_LEN'(k);
  endfunction

endpackage

// File: rtl/rice_encoder_bit_packer.sv
// MSB-first accumulator that packs variable-length segments into output words.
module bit_packer
  import rice_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             seg_valid,
  input  logic [W_OUT-1:0] seg_bits,
  input  logic [W_LEN-1:0] seg_len,
  output logic             seg_ready_c,
  input  logic             pad_req,
  output logic             pad_ready_c,
  output logic             fill_nz_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_last
);

  logic [W_ACC-1:0]  acc_q;
  logic [W_FILL-1:0] fill_q;
  logic [W_SH-1:0]   sh_c;
  logic              out_free_c;

  assign seg_ready_c = fill_q < W_FILL'(W_OUT);
  assign out_free_c  = !out_valid || out_ready;
  assign pad_ready_c = seg_ready_c && out_free_c;
  assign fill_nz_c   = fill_q != '0;
  // Segment bits are right-aligned; shift them to sit just below the filled region.
  assign sh_c        = W_SH'(W_ACC) - W_SH'(fill_q) - W_SH'(seg_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (!seg_ready_c && out_free_c) begin
      out_data  <= acc_q[W_ACC-1 -: W_OUT];
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      acc_q     <= acc_q << W_OUT;
      fill_q    <= fill_q - W_FILL'(W_OUT);
    end else if (pad_req && pad_ready_c && fill_nz_c) begin
      // Bits below the fill level are already zero, so the top word is the padded word.
      out_data  <= acc_q[W_ACC-1 -: W_OUT];
      out_valid <= 1'b1;
      out_last  <= 1'b1;
      acc_q     <= '0;
      fill_q    <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (seg_valid && seg_ready_c) begin
        acc_q  <= acc_q | (W_ACC'(seg_bits) << sh_c);
        fill_q <= fill_q + W_FILL'(seg_len);
      end
    end
  end

endmodule

// File: rtl/rice_encoder.sv
// Golomb-Rice encoder: codeword FSM and flush control in front of the bit packer.
module rice_encoder
  import rice_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_data,
  input  logic [W_K-1:0]    in_k,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_OUT-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              flush_pend_q;
  logic [W_LEN-1:0]  pre_len_q, suf_len_q;
  logic [W_DATA-1:0] suf_bits_q;

  logic              accept_c;
  logic [W_K-1:0]    k_eff_c;
  logic [W_DATA-1:0] q_c, r_c;
  logic              esc_c;

  logic              seg_valid_c, seg_ready_c, pad_req_c, pad_ready_c, fill_nz_c;
  logic [W_OUT-1:0]  seg_bits_c;
  logic [W_LEN-1:0]  seg_len_c;

  // Quotient / remainder split of the offered sample.
  assign accept_c = in_valid && in_ready;
  assign k_eff_c  = (32'(in_k) >= W_DATA) ? W_K'(W_DATA - 1) : in_k;
  assign q_c      = in_data >> k_eff_c;
  assign r_c      = in_data & ((W_DATA'(1) << k_eff_c) - W_DATA'(1));
  assign esc_c    = 32'(q_c) >= Q_ESC;

  assign busy = (state_q != IDLE) || fill_nz_c || out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = PREFIX;
        end else if (flush_pend_q) begin
          state_d = FLUSH;
        end
      end
      PREFIX: if (seg_ready_c) state_d = (suf_len_q == '0) ? IDLE : SUFFIX;
      SUFFIX: if (seg_ready_c) state_d = IDLE;
      FLUSH:  if (pad_ready_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    seg_valid_c = 1'b0;
    seg_bits_c  = '0;
    seg_len_c   = '0;
    pad_req_c   = 1'b0;
    unique case (state_q)
      IDLE: in_ready = !flush_pend_q;
      PREFIX: begin
        seg_valid_c = 1'b1;
        seg_bits_c  = W_OUT'(1);
        seg_len_c   = pre_len_q;
      end
      SUFFIX: begin
        seg_valid_c = 1'b1;
        seg_bits_c  = W_OUT'(suf_bits_q);
        seg_len_c   = suf_len_q;
      end
      FLUSH: pad_req_c = pad_ready_c;
      default: ;
    endcase
  end

  // Codeword capture on accept; flush request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_len_q    <= '0;
      suf_len_q    <= '0;
      suf_bits_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush || (flush_pend_q && !pad_req_c);
      if (accept_c) begin
        pre_len_q  <= seg_len(1'b1, esc_c, q_c, k_eff_c);
        suf_len_q  <= seg_len(1'b0, esc_c, q_c, k_eff_c);
        suf_bits_q <= esc_c ? in_data : r_c;
      end
    end
  end

  bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .seg_valid  (seg_valid_c),
    .seg_bits   (seg_bits_c),
    .seg_len    (seg_len_c),
    .seg_ready_c(seg_ready_c),
    .pad_req    (pad_req_c),
    .pad_ready_c(pad_ready_c),
    .fill_nz_c  (fill_nz_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_rice_encoder.sv
// Self-checking bench for rice_encoder against a bit-queue model of the codeword stream.
module tb_rice_encoder;

  logic        clk, rst;
  logic        in_valid, in_ready, flush;
  logic [15:0] in_data;
  logic [3:0]  in_k;
  logic        out_valid, out_ready, out_last, busy;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  bit          bitq[$];
  logic [32:0] expq[$];
  logic [32:0] seenq[$];
  bit          m_pend = 0;
  bit          hold_prev = 0;
  logic [32:0] hold_word;

  rice_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_k     (in_k),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [31:0] pop_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) begin
      w = {w[30:0], (bitq.size() > 0) ? bitq.pop_front() : 1'b0};
    end
    return w;
  endfunction

  // Reference codeword: unary quotient, '1', then remainder or raw escape payload.
  function automatic void push_code(input logic [15:0] d, input logic [3:0] k);
    int q = int'(d) >> k;
    if (q < 16) begin
      repeat (q) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = int'(k) - 1; i >= 0; i--) bitq.push_back(d[i]);
    end else begin
      repeat (16) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = 15; i >= 0; i--) bitq.push_back(d[i]);
    end
    while (bitq.size() >= 32) expq.push_back({1'b0, pop_word()});
  endfunction

  function automatic void model_flush();
    if (bitq.size() > 0) expq.push_back({1'b1, pop_word()});
  endfunction

  // Model update and output comparison, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      bitq.delete();
      expq.delete();
      m_pend = 0;
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_data}), 64'(hold_word));
      end
      hold_prev = out_valid && !out_ready;
      hold_word = {out_last, out_data};
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got 0x%0h expected no word", {out_last, out_data});
        end else begin
          check("word", 64'({out_last, out_data}), 64'(expq.pop_front()));
        end
        seenq.push_back({out_last, out_data});
        n_words++;
      end
      if (m_pend && in_ready) m_pend = 0;
      if (in_valid && in_ready) push_code(in_data, in_k);
      if (flush && !m_pend) begin
        model_flush();
        m_pend = 1;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic [3:0] k, input logic fl);
    bit done = 0;
    in_valid = 1; in_data = d; in_k = k; flush = fl;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1 flush = 0;
    end
    in_valid = 0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy && in_ready && !out_valid;
    end
    if (!ok) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    bit saw;
    logic [15:0] m;
    rst = 1; in_valid = 0; in_data = 0; in_k = 0; flush = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // k=2, data=9 -> 00101 padded
    base = n_words;
    send(16'd9, 4'd2, 1'b0);
    pulse_flush();
    wait_idle(100);
    check("t1_count", 64'(n_words - base), 64'd1);
    if (n_words > base) check("t1_word", 64'(seenq[base]), 64'({1'b1, 32'h2800_0000}));

    // 32 one-bit codewords fill exactly one word
    base = n_words;
    repeat (32) send(16'd0, 4'd0, 1'b0);
    wait_idle(100);
    check("t2_count", 64'(n_words - base), 64'd1);
    if (n_words > base) check("t2_word", 64'(seenq[base]), 64'({1'b0, 32'hFFFF_FFFF}));
    check("t2_busy", 64'(busy), 64'd0);

    // Escape codeword spans two words
    base = n_words;
    send(16'd20, 4'd0, 1'b0);
    pulse_flush();
    wait_idle(100);
    check("t3_count", 64'(n_words - base), 64'd2);
    if (n_words > base + 1) begin
      check("t3_word0", 64'(seenq[base]), 64'({1'b0, 32'h0000_800A}));
      check("t3_word1", 64'(seenq[base + 1]), 64'({1'b1, 32'h0000_0000}));
    end

    // Backpressure with a continuous stream
    out_ready = 0; in_valid = 1; in_data = 0; in_k = 0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    pulse_flush();
    wait_idle(2000);
    check("bp_drained", 64'(expq.size()), 64'd0);

    // Flush with empty accumulator emits nothing
    base = n_words; saw = 0;
    pulse_flush();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("f0_no_valid", 64'(saw), 64'd0);
    check("f0_busy", 64'(busy), 64'd0);
    check("f0_count", 64'(n_words - base), 64'd0);
    @(posedge clk); #1;

    // Flush in the same cycle as the accept
    base = n_words;
    send(16'd9, 4'd2, 1'b1);
    wait_idle(100);
    check("fa_count", 64'(n_words - base), 64'd1);
    if (n_words > base) check("fa_word", 64'(seenq[base]), 64'({1'b1, 32'h2800_0000}));

    // Reset in SUFFIX with a held output word
    out_ready = 0;
    repeat (32) send(16'd0, 4'd0, 1'b0);
    send(16'd9, 4'd2, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_data", 64'(out_data), 64'd0);
    check("mrst_out_last", 64'(out_last), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0; out_ready = 1;
    base = n_words;
    send(16'd9, 4'd2, 1'b1);
    wait_idle(100);
    check("mrst_count", 64'(n_words - base), 64'd1);
    if (n_words > base) check("mrst_word", 64'(seenq[base]), 64'({1'b1, 32'h2800_0000}));

    // Randomized traffic, flushes and backpressure
    for (int c = 0; c < 3000; c++) begin
      m = 16'((32'd1 << $urandom_range(1, 16)) - 32'd1);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_k      = 4'($urandom_range(0, 9));
      in_data   = 16'($urandom) & m;
      flush     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    pulse_flush();
    wait_idle(5000);
    check("final_expq_empty", 64'(expq.size()), 64'd0);
    check("final_bitq_empty", 64'(bitq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
